// File: rtl/kogge_stone_bist_pkg.sv
// Shared types and helpers for the Kogge-Stone adder BIST.
// Default widths, FSM state type and the reference sum.
package kogge_stone_bist_pkg;

  localparam int KSA_WIDTH   = 4;
  localparam int KSA_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Callers zero-extend operands and truncate to WIDTH+1 bits.
  function automatic logic [32:0] ksa_expect(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        cin
  );
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

endpackage

// File: rtl/kogge_stone_bist_if.sv
// Operand/result bundle between the BIST engine and the adder.
// master = BIST side, slave = adder side.
interface kogge_stone_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output a, b, cin, input sum, cout);
  modport slave  (input a, b, cin, output sum, cout);
endinterface

// File: rtl/ksa_bist_delay.sv
// Valid-tagged shift register aligning expected results
// with the adder latency; synchronous clear.
module ksa_bist_delay #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [DATA_W-1:0] dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      for (int i = 1; i < DEPTH; i++)
        vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dat_q[0] <= in_data_i;
    for (int i = 1; i < DEPTH; i++)
      dat_q[i] <= dat_q[i-1];
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/kogge_stone_bist.sv
// Exhaustive BIST engine for a WIDTH-bit adder of fixed LATENCY.
// KSA_BIST_FIRST_FAIL_CAPTURE_EN adds first-mismatch capture.
module kogge_stone_bist
  import kogge_stone_bist_pkg::*;
#(
  parameter int WIDTH   = KSA_WIDTH,
  parameter int LATENCY = KSA_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count
`ifdef KSA_BIST_FIRST_FAIL_CAPTURE_EN
  ,
  output logic [2*WIDTH:0] first_fail_vec,
  output logic             first_fail_valid
`endif
);

  localparam int CW = 2*WIDTH + 1;
  localparam int DW = $clog2(LATENCY + 1);
  localparam int RW = WIDTH + 1;
`ifdef KSA_BIST_FIRST_FAIL_CAPTURE_EN
  localparam int DATA_W = RW + CW;
`else
  localparam int DATA_W = RW;
`endif
  localparam logic [CW-1:0] CNT_LAST = '1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [15:0]     err_q, err_d;
  logic [RW-1:0]   exp_w;
  logic            start_ok;
  logic            dly_vld;
  logic [DATA_W-1:0] dly_in, dly_out;
  logic            mis;

  assign start_ok = start &&
    (state_q == ST_IDLE || state_q == ST_DONE);

  assign {dut_a, dut_b, dut_cin} =
    (state_q == ST_RUN) ? cnt_q : '0;

  assign exp_w = RW'(ksa_expect(
    32'(dut_a), 32'(dut_b), dut_cin));

`ifdef KSA_BIST_FIRST_FAIL_CAPTURE_EN
  assign dly_in = {cnt_q, exp_w};
`else
  assign dly_in = exp_w;
`endif

  ksa_bist_delay #(
    .DEPTH  (LATENCY),
    .DATA_W (DATA_W)
  ) u_dly (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_ok),
    .in_valid_i  (state_q == ST_RUN),
    .in_data_i   (dly_in),
    .out_valid_o (dly_vld),
    .out_data_o  (dly_out)
  );

  assign mis = dly_vld &&
    (dly_out[RW-1:0] != {dut_cout, dut_sum});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    err_d   = err_q;
    if (mis && err_q != 16'hFFFF)
      err_d = err_q + 16'd1;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          err_d   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // One extra cycle lets the last compare land before done.
      ST_DRAIN: begin
        if (drn_q == DW'(LATENCY))
          state_d = ST_DONE;
        else
          drn_d = drn_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
    end
  end

`ifdef KSA_BIST_FIRST_FAIL_CAPTURE_EN
  logic [CW-1:0] ffv_q;
  logic          ffok_q;

  always_ff @(posedge clk) begin
    if (!rst || start_ok) begin
      ffv_q  <= '0;
      ffok_q <= 1'b0;
    end else if (mis && !ffok_q) begin
      ffv_q  <= dly_out[DATA_W-1:RW];
      ffok_q <= 1'b1;
    end
  end

  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffok_q;
`endif

  assign busy      = (state_q == ST_RUN) ||
                     (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == 16'd0);
  assign err_count = err_q;

endmodule
